// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared Z80 bus types, T-state constants and strobe decode
package z80_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        TW,
        T3,
        DONE
    } io_state_t;

    // Minimum T-states of an I/O cycle: T1, T2, one automatic TW, T3
    localparam int T_STATES_IO = 4;

    typedef struct packed {
        logic iorq_n;
        logic rd_n;
        logic wr_n;
    } io_strobes_t;

    localparam logic IORQ_OFF = 1'b1;
    localparam logic RD_OFF   = 1'b1;
    localparam logic WR_OFF   = 1'b1;
    localparam io_strobes_t STROBES_OFF = '{iorq_n: IORQ_OFF, rd_n: RD_OFF, wr_n: WR_OFF};

    function automatic logic io_in_cycle(input io_state_t st);
        return (st == T1) || (st == T2) || (st == TW) || (st == T3);
    endfunction

    // rd_n/wr_n only ever fall together with iorq_n, and never both
    function automatic io_strobes_t io_strobes(input io_state_t st, input logic wr);
        io_strobes_t s;
        s = STROBES_OFF;
        if ((st == T2) || (st == TW) || (st == T3)) begin
            s.iorq_n = 1'b0;
            s.rd_n   = wr;
            s.wr_n   = ~wr;
        end
        return s;
    endfunction

endpackage

// File: rtl/z80_tstate_timer.sv
// rtl/z80_tstate_timer.sv - T_DIV clk prescaler marking the last clk of each T-state
module z80_tstate_timer #(
    parameter int T_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic last_tick
);

    localparam int CNT_W = $clog2(T_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(T_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load || last_tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign last_tick = (count == LAST);

endmodule

// File: rtl/z80_io_master.sv
// rtl/z80_io_master.sv - Z80 IN/OUT bus initiator; define Z80_IO_MASTER_WAIT_EN to honour wait_n
module z80_io_master
    import z80_bus_pkg::*;
#(
    parameter int T_DIV  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rdata,
    output logic [ADDR_W-1:0] A,
    inout  wire  [7:0]        cd,
    output logic              iorq_n,
    output logic              rd_n,
    output logic              wr_n,
    input  logic              wait_n
);

    io_state_t   state_q, state_d;
    io_strobes_t strb_q;
    logic        accept;
    logic        wr_q, wr_d;
    logic [7:0]  wdata_q;
    logic        cd_oe;
    logic        last_tick;
    logic        timer_load;

`ifdef Z80_IO_MASTER_WAIT_EN
    logic wait_ok;
    assign wait_ok = wait_n;
`else
    logic unused_wait_n;
    assign unused_wait_n = wait_n;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    state_d = T1;
                end
            end
            T1: if (last_tick) state_d = T2;
            T2: if (last_tick) state_d = TW;
            TW: begin
`ifdef Z80_IO_MASTER_WAIT_EN
                if (last_tick && wait_ok) state_d = T3;
`else
                if (last_tick) state_d = T3;
`endif
            end
            T3: if (last_tick) state_d = DONE;
            DONE: begin
                // busy is already low here, so a request in this clk starts the next cycle
                if (req) begin
                    accept  = 1'b1;
                    state_d = T1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_d = accept ? req_wr : wr_q;

    // Hold the prescaler at zero outside a bus cycle and restart it on every state entry
    assign timer_load = (state_d != state_q) || !io_in_cycle(state_q);

    z80_tstate_timer #(
        .T_DIV(T_DIV)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load),
        .last_tick(last_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
            A       <= '0;
            strb_q  <= STROBES_OFF;
            cd_oe   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            busy    <= io_in_cycle(state_d);
            done    <= (state_d == DONE);
            strb_q  <= io_strobes(state_d, wr_d);
            cd_oe   <= io_in_cycle(state_d) && wr_d;
            if (accept) begin
                A       <= req_addr;
                wr_q    <= req_wr;
                wdata_q <= req_wdata;
            end
            if ((state_q == T3) && last_tick && !wr_q) begin
                rdata <= cd;
            end
        end
    end

    assign cd     = cd_oe ? wdata_q : 8'hzz;
    assign iorq_n = strb_q.iorq_n;
    assign rd_n   = strb_q.rd_n;
    assign wr_n   = strb_q.wr_n;

endmodule

// File: doc/z80_io_master.md
Name: z80_io_master

Overview:
- Z80-style I/O bus initiator. It turns a single-cycle internal request into a full IN/OUT bus cycle: A, cd, iorq_n, rd_n and wr_n with T1/T2/TW/T3 timing.
- Drives the same external bus our I/O decode responder listens on. Used by internal masters (soft CPU, self-test sequencer) and as the bus driver in system benches.
- One outstanding transaction at a time; a done pulse returns read data.

Parameters:
- T_DIV, 4, clk cycles per emulated T-state (legal range 2..255).
- ADDR_W, 8, I/O address width driven on A.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- req  input  1  start a transaction; sampled only while busy=0
- req_wr  input  1  1=OUT (write), 0=IN (read); captured with req
- req_addr  input  ADDR_W  port address; captured with req
- req_wdata  input  8  write data; captured with req
- busy  output  1  high from the clock after req acceptance until done
- done  output  1  one-clock pulse at end of transaction
- rdata  output  8  read data; valid from done, held until next done
- A  output  ADDR_W  bus address
- cd  inout  8  bus data; driven only during write cycles, otherwise Z
- iorq_n  output  1  I/O request strobe, active low
- rd_n  output  1  read strobe, active low
- wr_n  output  1  write strobe, active low
- wait_n  input  1  bus wait request, active low

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous and active-low (reset_n).
- Reset values: busy=0, done=0, rdata=0, A=0, iorq_n=rd_n=wr_n=1, cd=Z; FSM goes to IDLE; T-state prescaler cleared.
- Reset mid-cycle: strobes deassert immediately (asynchronously); the transaction is discarded with no done pulse.
- FSM states: IDLE, T1, T2, TW, T3, DONE. Each T-state lasts exactly T_DIV clks, counted by the prescaler. Prescaler is reloaded on each state entry.
- IDLE:
  - req=1 captures req_wr, req_addr and req_wdata; busy=1; enter T1 on the next clk.
  - req while busy=1 is ignored; it is neither queued nor an error.
- T1:
  - A=captured addr.
  - If write: cd driven with captured wdata from the first clk of T1 until the end of T3.
  - All strobes stay high.
- T2: iorq_n=0, plus rd_n=0 (read) or wr_n=0 (write), asserted on the first clk of T2.
- TW: one automatic wait state (Z80 I/O rule); strobes held.
- T3:
  - Strobes held.
  - Read: rdata is loaded from cd on the last clk of T3.
  - On exit from T3, iorq_n, rd_n and wr_n go high together and cd returns to Z.
- DONE:
  - done=1 for one clk, busy=0 in the same clk, then IDLE.
  - A holds the last address until the next T1.
- Latency: req accepted at clk 0; T1 begins at clk 1; done at clk 1+4*T_DIV. With T_DIV=4, done is at clk 17.
- Back-to-back: req may be asserted in the same clk as done. It is accepted because busy=0 in that clk, so successive strobe deassertions are at least T_DIV clks apart (T1 gap).
- Strobe exclusivity: rd_n and wr_n are never low simultaneously, and neither is ever low while iorq_n=1.
- Prescaler counts 0..T_DIV-1 and wraps; there is no overflow path.

Optional Feature:
- Macro: Z80_IO_MASTER_WAIT_EN.
- Defined: wait_n is sampled on the last clk of each TW. If wait_n=0, a further TW is inserted (repeated without limit); if wait_n=1, go to T3.
- Not defined: wait_n is ignored; exactly one TW is always inserted. The port stays present so wiring is unchanged.

Decomposition:
- Shared package z80_bus_pkg holds:
  - enum io_state_t {IDLE,T1,T2,TW,T3,DONE};
  - localparam T_STATES_IO=4;
  - strobe-inactive constants.
- One sub-module, z80_tstate_timer: a T_DIV prescaler with a load input and a last_tick output, reusable for future memory-cycle masters.

Test Plan:
- Write, T_DIV=4: req_wr=1, addr=0x98, wdata=0x5A -> A=0x98 from clk 1; iorq_n=wr_n=0 during clks 5..16 with cd=0x5A; rd_n stays 1; done at clk 17; cd=Z afterwards.
- Read: responder drives cd=0xA5 while rd_n=0, addr=0x99 -> iorq_n=rd_n=0 during clks 5..16; rdata=0xA5 at done (clk 17); cd never driven by the DUT.
- Back-to-back: a write to 0x98 followed by a read of 0x30, with the second req asserted in the done clk -> second T1 begins the next clk; strobes high for at least T_DIV clks between the two cycles.
- Ignored request: req pulsed while busy=1 -> no extra cycle; exactly one done.
- Reset mid-cycle: reset_n=0 during T2 -> strobes=1 and cd=Z immediately; busy=0; no done pulse; a new req after release completes normally.
- Wait (Z80_IO_MASTER_WAIT_EN defined): wait_n=0 for 2 TW samples -> strobe-low interval extends by 2*T_DIV clks; done at clk 25 with T_DIV=4. With the macro undefined, the same stimulus gives done at clk 17.
